// File: rtl/sha_stream_scheduler.sv
// Round-robin, message-granular arbiter sharing one padder/hash engine among NUM_REQ AXI4-Streams.
// Optional per-requester completed-message counters behind `SHA_SCHED_STATS_EN.
module sha_stream_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          axi_aclk,
    input  logic                          axi_reset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_REQ*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_REQ-1:0]            s_axis_tvalid,
    input  logic [NUM_REQ-1:0]            s_axis_tlast,
    output logic [NUM_REQ-1:0]            s_axis_tready,
    input  logic [NUM_REQ-1:0]            s_sha_type,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic                          en,
    output logic                          sha_type,
    input  logic                          hash_done,
    output logic [NUM_REQ-1:0]            grant,
`ifdef SHA_SCHED_STATS_EN
    output logic [NUM_REQ*16-1:0]         msg_count,
`endif
    output logic                          busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [1:0]           state;
    logic [IDX_WIDTH-1:0] idx;
    logic [IDX_WIDTH-1:0] last_grant;
    logic [IDX_WIDTH-1:0] next_idx;
    logic                 req_any;
    logic                 streaming;
    logic                 done_acc;

    // Scan from farthest to nearest so the first requester after last_grant wins.
    always_comb begin
        int c;
        c        = 0;
        next_idx = last_grant;
        req_any  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            c = (int'(last_grant) + k) % NUM_REQ;
            if (s_axis_tvalid[c]) begin
                next_idx = IDX_WIDTH'(c);
                req_any  = 1'b1;
            end
        end
    end

    assign streaming     = (state == S_STREAM);
    assign done_acc      = (state == S_WAIT) && hash_done;
    assign busy          = (state != S_IDLE);
    assign en            = busy;
    assign m_axis_tdata  = s_axis_tdata[idx*DATA_WIDTH +: DATA_WIDTH];
    assign m_axis_tkeep  = s_axis_tkeep[idx*KEEP_WIDTH +: KEEP_WIDTH];
    assign m_axis_tvalid = streaming && s_axis_tvalid[idx];
    assign m_axis_tlast  = streaming && s_axis_tlast[idx];

    always_comb begin
        s_axis_tready = '0;
        if (streaming) begin
            s_axis_tready[idx] = m_axis_tready;
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            last_grant <= IDX_WIDTH'(NUM_REQ - 1);
            grant      <= '0;
            sha_type   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        idx      <= next_idx;
                        grant    <= NUM_REQ'(1) << next_idx;
                        sha_type <= s_sha_type[next_idx];
                        state    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (hash_done) begin
                        last_grant <= idx;
                        grant      <= '0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SHA_SCHED_STATS_EN
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            msg_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (done_acc && (int'(idx) == i)) begin
                    msg_count[i*16 +: 16] <= msg_count[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
